// File: rtl/fpu_host_link.sv
// rtl/fpu_host_link.sv - byte-serial host bridge that loads two FPU operands, restarts the FPU and returns result+status
module fpu_host_link #(
    parameter int FPU_LATENCY = 16
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] op_A_out,
    output logic [31:0] op_B_out,
    output logic        fpu_reset,
    input  logic [31:0] fpu_data_in,
    input  logic [3:0]  fpu_status_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);
    typedef enum logic [1:0] {RX, KICK, WAIT, TX} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(FPU_LATENCY - 1);

    state_t      state_q, state_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [55:0] shadow_q, shadow_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  status_q, status_d;
    logic [7:0]  tx_byte;

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state_q    <= RX;
            rx_cnt_q   <= '0;
            shadow_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            wait_cnt_q <= '0;
            tx_cnt_q   <= '0;
            result_q   <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            rx_cnt_q   <= rx_cnt_d;
            shadow_q   <= shadow_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            wait_cnt_q <= wait_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            result_q   <= result_d;
            status_q   <= status_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rx_cnt_d   = rx_cnt_q;
        shadow_d   = shadow_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        wait_cnt_d = wait_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        result_d   = result_q;
        status_d   = status_q;
        case (state_q)
            RX: begin
                if (rx_valid) begin
                    shadow_d = {shadow_q[47:0], rx_data};
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    // Seven bytes sit in the shadow; the eighth is taken straight from the bus
                    if (rx_cnt_q == 3'd7) begin
                        op_a_d  = shadow_q[55:24];
                        op_b_d  = {shadow_q[23:0], rx_data};
                        state_d = KICK;
                    end
                end
            end
            KICK: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    result_d = fpu_data_in;
                    status_d = fpu_status_in;
                    tx_cnt_d = '0;
                    state_d  = TX;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            TX: begin
                if (tx_ready) begin
                    if (tx_cnt_q == 3'd4) begin
                        tx_cnt_d = '0;
                        state_d  = RX;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = RX;
        endcase
    end

    always_comb begin
        tx_byte = '0;
        case (tx_cnt_q)
            3'd0:    tx_byte = result_q[31:24];
            3'd1:    tx_byte = result_q[23:16];
            3'd2:    tx_byte = result_q[15:8];
            3'd3:    tx_byte = result_q[7:0];
            3'd4:    tx_byte = {4'b0000, status_q};
            default: tx_byte = '0;
        endcase
    end

    assign rx_ready  = (state_q == RX);
    assign busy      = (state_q != RX);
    assign fpu_reset = (state_q == KICK);
    assign tx_valid  = (state_q == TX);
    assign tx_data   = (state_q == TX) ? tx_byte : 8'h00;
    assign op_A_out  = op_a_q;
    assign op_B_out  = op_b_q;
endmodule

// File: tb/tb_fpu_host_link.sv
// tb/tb_fpu_host_link.sv - directed bench for fpu_host_link
`timescale 1ns/1ps
module tb_fpu_host_link;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] op_A_out, op_B_out;
    logic        fpu_reset;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    int tests = 0;
    int fails = 0;

    fpu_host_link #(.FPU_LATENCY(16)) dut (
        .clock100KHz   (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .op_A_out      (op_A_out),
        .op_B_out      (op_B_out),
        .fpu_reset     (fpu_reset),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_bytes(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data  = v[63 - 8*i -: 8];
            rx_valid = 1'b1;
            tick();
        end
    endtask

    // Called one cycle into KICK; drives the FPU result until the capture edge, then scrambles it
    task automatic run_wait(input logic [31:0] res, input logic [3:0] st);
        fpu_data_in   = res;
        fpu_status_in = st;
        tick();
        check("kick_one_cycle", fpu_reset, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check("wait_last_cycle_no_tx", tx_valid, 1'b0);
        check("wait_rx_ready_low", rx_ready, 1'b0);
        tick();
        fpu_data_in   = 32'hDEADBEEF;
        fpu_status_in = 4'hF;
        check("tx_entered", tx_valid, 1'b1);
    endtask

    logic [7:0] exp1 [5];
    logic [7:0] exp2 [5];

    initial begin
        exp1 = '{8'h40, 8'h40, 8'h00, 8'h00, 8'h01};
        exp2 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        fpu_data_in = 32'h0; fpu_status_in = 4'h0;
        tick(); tick();
        reset = 1'b0;
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_fpu_reset", fpu_reset, 1'b0);
        check("rst_op_a", op_A_out, 32'h0);
        check("rst_op_b", op_B_out, 32'h0);

        // Run 1: continuous rx, garbage on rx during WAIT/TX, tx_ready held high
        load_bytes(64'h3F800000_40000000, 7);
        check("op_a_before_8th", op_A_out, 32'h0);
        load_bytes(64'h00000000_00000000, 1);
        rx_data = 8'hA5;
        check("load1_op_a", op_A_out, 32'h3F800000);
        check("load1_op_b", op_B_out, 32'h40000000);
        check("load1_fpu_reset", fpu_reset, 1'b1);
        check("load1_busy", busy, 1'b1);
        check("load1_rx_ready", rx_ready, 1'b0);
        run_wait(32'h40400000, 4'b0001);
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("run1_tx_valid", tx_valid, 1'b1);
            check($sformatf("run1_tx_byte%0d", i), tx_data, exp1[i]);
            check("run1_rx_ready_low", rx_ready, 1'b0);
            rx_data = 8'h5A ^ 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        check("run1_back_rx_ready", rx_ready, 1'b1);
        check("run1_back_tx_valid", tx_valid, 1'b0);
        check("run1_back_busy", busy, 1'b0);
        check("run1_hold_op_a", op_A_out, 32'h3F800000);
        check("run1_hold_op_b", op_B_out, 32'h40000000);
        tick();

        // Run 2: tx_ready toggling; new load must start at byte 0
        load_bytes(64'hC0A00000_41200000, 8);
        rx_valid = 1'b0;
        check("load2_op_a", op_A_out, 32'hC0A00000);
        check("load2_op_b", op_B_out, 32'h41200000);
        check("load2_fpu_reset", fpu_reset, 1'b1);
        run_wait(32'h12345678, 4'hA);
        for (int i = 0; i < 5; i++) begin
            tx_ready = 1'b0;
            check($sformatf("run2_byte%0d", i), tx_data, exp2[i]);
            tick();
            check($sformatf("run2_hold%0d", i), tx_data, exp2[i]);
            check("run2_tx_valid", tx_valid, 1'b1);
            tx_ready = 1'b1;
            tick();
        end
        tx_ready = 1'b0;
        check("run2_back_rx_ready", rx_ready, 1'b1);
        check("run2_back_tx_valid", tx_valid, 1'b0);

        // Run 3: reset mid-load discards the partial operand and never kicks the FPU
        load_bytes(64'h11223344_55667788, 5);
        rx_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_mid_fpu_reset", fpu_reset, 1'b0);
        check("rst_mid_op_a", op_A_out, 32'h0);
        check("rst_mid_op_b", op_B_out, 32'h0);
        reset = 1'b0;
        tick();
        check("rst_mid_fpu_reset2", fpu_reset, 1'b0);
        check("rst_mid_rx_ready", rx_ready, 1'b1);
        load_bytes(64'h3F800000_40000000, 8);
        rx_valid = 1'b0;
        check("load3_op_a", op_A_out, 32'h3F800000);
        check("load3_op_b", op_B_out, 32'h40000000);
        check("load3_fpu_reset", fpu_reset, 1'b1);
        run_wait(32'hCAFEF00D, 4'h3);
        tx_ready = 1'b1;
        check("run3_byte0", tx_data, 8'hCA);
        for (int i = 0; i < 5; i++) tick();
        check("run3_back_rx_ready", rx_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpu_host_link.md
FPU_HOST_LINK -- requirements
Module: fpu_host_link

Interface
REQ-001 SHALL have parameter FPU_LATENCY, default 16: cycles waited after FPU restart before capturing the result; legal range 1..255.
REQ-002 SHALL have port clock100KHz  input  1  the single clock; all logic on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  operand byte from host.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  block accepts a byte this cycle.
REQ-007 SHALL have port op_A_out  output  32  operand A driven to the FPU op_A_in.
REQ-008 SHALL have port op_B_out  output  32  operand B driven to the FPU op_B_in.
REQ-009 SHALL have port fpu_reset  output  1  restart pulse driven to the FPU reset.
REQ-010 SHALL have port fpu_data_in  input  32  FPU data_out.
REQ-011 SHALL have port fpu_status_in  input  4  FPU status_out.
REQ-012 SHALL have port tx_data  output  8  result byte to host.
REQ-013 SHALL have port tx_valid  output  1  tx_data valid.
REQ-014 SHALL have port tx_ready  input  1  host accepts tx_data.
REQ-015 SHALL have port busy  output  1  high in every state except RX.

Function
REQ-016 SHALL implement the states RX, KICK, WAIT and TX.
REQ-017 In RX, rx_ready SHALL be 1, and a byte SHALL be accepted on each cycle with rx_valid=1.
REQ-018 The byte stream SHALL be 8 bytes, big-endian: A[31:24], A[23:16], A[15:8], A[7:0], then B[31:24] down to B[7:0].
REQ-019 Accepted bytes SHALL accumulate in shadow registers; op_A_out and op_B_out SHALL update together only on the cycle the 8th byte is accepted.
REQ-020 After the 8th byte the FSM SHALL enter KICK; fpu_reset SHALL be 1 for exactly that one cycle.
REQ-021 rx_ready SHALL be 0 in KICK, WAIT and TX; rx_valid SHALL be ignored there, and no byte SHALL be lost-counted.
REQ-022 In WAIT, an 8-bit counter SHALL run from 0; on the cycle it equals FPU_LATENCY-1, fpu_data_in and fpu_status_in SHALL be captured, and the FSM SHALL enter TX.
REQ-023 With FPU_LATENCY=N, the capture edge SHALL be N cycles after the KICK cycle's edge.
REQ-024 TX SHALL send 5 bytes: result[31:24], [23:16], [15:8], [7:0], then {4'b0000, status}.
REQ-025 In TX, tx_valid SHALL be 1, and a byte SHALL advance only on a cycle with tx_valid=1 and tx_ready=1.
REQ-026 While tx_ready=0, tx_data SHALL hold stable.
REQ-027 After the 5th handshake, the FSM SHALL return to RX in the next cycle with tx_valid=0 and the byte counter at 0.
REQ-028 op_A_out and op_B_out SHALL hold their values through KICK, WAIT, TX and the following RX, until the next full 8-byte load.
REQ-029 Changes on fpu_data_in and fpu_status_in outside the capture cycle SHALL have no effect.
REQ-030 If tx_ready=1 continuously, the 5 bytes SHALL go out on 5 consecutive cycles.

Reset
REQ-031 reset=1 at a clock edge SHALL force: state RX; rx/tx byte counters and the wait counter 0; rx_ready=1 from the first cycle after reset deasserts.
REQ-032 reset=1 at a clock edge SHALL force: tx_valid=0, tx_data=0, fpu_reset=0, busy=0.
REQ-033 reset=1 at a clock edge SHALL force op_A_out, op_B_out, the shadow registers and the captured result/status to 0.
REQ-034 reset SHALL override all other inputs in any state; a partial operand load or transmit in progress SHALL be discarded.
REQ-035 The block SHALL never pulse fpu_reset as a side-effect of its own reset.

Verification
REQ-036 Load 3F 80 00 00 40 00 00 00 with rx_valid held 1 -> op_A_out=0x3F800000 and op_B_out=0x40000000 on the same edge; a one-cycle fpu_reset pulse on the next cycle; busy=1.
REQ-037 FPU_LATENCY=16, bench drives fpu_data_in=0x40400000 and fpu_status_in=4'b0001 at the capture cycle, tx_ready=1 -> tx bytes 40 40 00 00 01 on 5 consecutive cycles, then rx_ready=1.
REQ-038 Same run with tx_ready toggled 0/1 every cycle -> tx_data stable while tx_ready=0, same 5-byte sequence, no duplicates.
REQ-039 rx_valid=1 with garbage bytes during WAIT and TX -> rx_ready=0; op_A_out and op_B_out unchanged; the next load starts at byte 0.
REQ-040 reset asserted after the 5th rx byte -> op_A_out=0, no fpu_reset pulse; a subsequent full load works normally.
REQ-041 fpu_data_in changed at capture cycle+1 -> the transmitted result equals the value present at the capture cycle.
